// File: rtl/edge_seq.sv
// Address/control sequencer for the Sobel edge-detection accelerator.
// Streams 3-row read windows column by column and issues result writes with border flags.
module edge_seq #(
   parameter int WORDS_PER_ROW = 88,
   parameter int ROWS          = 288,
   parameter int DST_OFFSET    = 25344,
   parameter int AW            = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          finish,
   output logic [AW-1:0] addr,
   output logic          en,
   output logic          we,
   output logic          ld_valid,
   output logic [1:0]    ld_slot,
   output logic          shift,
   output logic          row_start,
   output logic          wr_valid,
   output logic          left_edge,
   output logic          right_edge,
   output logic          zero_row
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = (WORDS_PER_ROW > 2) ? $clog2(WORDS_PER_ROW) : 1;

   localparam logic [AW-1:0]    WPR_A      = AW'(WORDS_PER_ROW);
   localparam logic [AW-1:0]    DST_A      = AW'(DST_OFFSET);
   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] PEN_ROW    = ROW_W'(ROWS - 2);
   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(WORDS_PER_ROW - 1);
   localparam logic [COL_W-1:0] PEN_COL    = COL_W'(WORDS_PER_ROW - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_BORDER, S_RD0, S_RD1, S_RD2, S_SETTLE, S_WR, S_DONE
   } state_t;

   state_t           state, state_d;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;     // column being written
   logic [COL_W-1:0] rd_col;  // column being read
   logic             prime;   // reading column 0 of an interior row
   logic [AW-1:0]    rb_prev, rb_cur, rb_next, wb;

   logic last_col, last_row, pen_row, pen_col;
   state_t row_end_state;

   assign last_col = (col == LAST_COL);
   assign pen_col  = (col == PEN_COL);
   assign last_row = (row == LAST_ROW);
   assign pen_row  = (row == PEN_ROW);

   always_comb begin
      if (last_row)
         row_end_state = S_DONE;
      else if (pen_row)
         row_end_state = S_BORDER;
      else
         row_end_state = S_RD0;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset)
         state <= S_IDLE;
      else
         state <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned, which would infer a latch.
      state_d = state;
      case (state)
         S_IDLE:   if (start) state_d = S_BORDER;
         S_BORDER: if (last_col) state_d = row_end_state;
         S_RD0:    state_d = S_RD1;
         S_RD1:    state_d = S_RD2;
         S_RD2:    state_d = S_SETTLE;
         S_SETTLE: state_d = prime ? S_RD0 : S_WR;
         S_WR: begin
            if (last_col)
               state_d = row_end_state;
            else if (pen_col)
               state_d = S_WR;
            else
               state_d = S_RD0;
         end
         S_DONE:   if (!start) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Row/column counters and incrementally maintained row base addresses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row     <= '0;
         col     <= '0;
         rd_col  <= '0;
         prime   <= 1'b0;
         rb_prev <= '0;
         rb_cur  <= '0;
         rb_next <= '0;
         wb      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  row     <= '0;
                  col     <= '0;
                  rd_col  <= '0;
                  prime   <= 1'b0;
                  rb_prev <= '0 - WPR_A;  // becomes 0 when row 1 is reached
                  rb_cur  <= '0;
                  rb_next <= WPR_A;
                  wb      <= DST_A;
               end
            end
            S_BORDER, S_WR: begin
               if (last_col) begin
                  row     <= row + ROW_W'(1);
                  col     <= '0;
                  rd_col  <= '0;
                  prime   <= 1'b1;
                  rb_prev <= rb_prev + WPR_A;
                  rb_cur  <= rb_cur + WPR_A;
                  rb_next <= rb_next + WPR_A;
                  wb      <= wb + WPR_A;
               end else begin
                  col <= col + COL_W'(1);
                  if (state == S_WR && !pen_col)
                     rd_col <= rd_col + COL_W'(1);
               end
            end
            S_SETTLE: begin
               if (prime) begin
                  prime  <= 1'b0;
                  rd_col <= rd_col + COL_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Load strobes describe the word arriving on dataR, one cycle after its read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_valid  <= 1'b0;
         ld_slot   <= 2'd0;
         shift     <= 1'b0;
         row_start <= 1'b0;
      end else begin
         ld_valid  <= (state == S_RD0) || (state == S_RD1) || (state == S_RD2);
         ld_slot   <= (state == S_RD1) ? 2'd1 : (state == S_RD2) ? 2'd2 : 2'd0;
         shift     <= (state == S_RD0) && !prime;
         row_start <= (state == S_RD0) && prime;
      end
   end

   // Access and handshake outputs
   always_comb begin
      addr       = '0;
      en         = 1'b0;
      we         = 1'b0;
      finish     = 1'b0;
      left_edge  = 1'b0;
      right_edge = 1'b0;
      zero_row   = 1'b0;
      case (state)
         S_BORDER: begin
            en         = 1'b1;
            we         = 1'b1;
            addr       = wb + AW'(col);
            zero_row   = 1'b1;
            left_edge  = (col == '0);
            right_edge = last_col;
         end
         S_RD0: begin
            en   = 1'b1;
            addr = rb_prev + AW'(rd_col);
         end
         S_RD1: begin
            en   = 1'b1;
            addr = rb_cur + AW'(rd_col);
         end
         S_RD2: begin
            en   = 1'b1;
            addr = rb_next + AW'(rd_col);
         end
         S_WR: begin
            en         = 1'b1;
            we         = 1'b1;
            addr       = wb + AW'(col);
            left_edge  = (col == '0);
            right_edge = last_col;
         end
         S_DONE:  finish = 1'b1;
         default: ;
      endcase
      wr_valid = en && we;
   end

endmodule

// File: tb/tb_edge_seq.sv
// Directed self-checking bench for edge_seq: a 2x3 image traced cycle by cycle
// and a 4x8 image checked for coverage, reset recovery and cycle count.
module tb_edge_seq;

   logic clk = 1'b0;
   logic reset;
   logic start_s, start_b;

   logic        s_finish, s_en, s_we, s_ld_valid, s_shift, s_row_start;
   logic        s_wr_valid, s_left_edge, s_right_edge, s_zero_row;
   logic [15:0] s_addr;
   logic [1:0]  s_ld_slot;

   logic        b_finish, b_en, b_we, b_ld_valid, b_shift, b_row_start;
   logic        b_wr_valid, b_left_edge, b_right_edge, b_zero_row;
   logic [15:0] b_addr;
   logic [1:0]  b_ld_slot;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   edge_seq #(.WORDS_PER_ROW(2), .ROWS(3), .DST_OFFSET(6), .AW(16)) u_small (
      .clk(clk), .reset(reset), .start(start_s), .finish(s_finish),
      .addr(s_addr), .en(s_en), .we(s_we), .ld_valid(s_ld_valid),
      .ld_slot(s_ld_slot), .shift(s_shift), .row_start(s_row_start),
      .wr_valid(s_wr_valid), .left_edge(s_left_edge),
      .right_edge(s_right_edge), .zero_row(s_zero_row)
   );

   edge_seq #(.WORDS_PER_ROW(4), .ROWS(8), .DST_OFFSET(32), .AW(16)) u_big (
      .clk(clk), .reset(reset), .start(start_b), .finish(b_finish),
      .addr(b_addr), .en(b_en), .we(b_we), .ld_valid(b_ld_valid),
      .ld_slot(b_ld_slot), .shift(b_shift), .row_start(b_row_start),
      .wr_valid(b_wr_valid), .left_edge(b_left_edge),
      .right_edge(b_right_edge), .zero_row(b_zero_row)
   );

   // {finish, en, we, addr, zero_row, left, right, wr_valid, ld_valid, ld_slot, shift, row_start}
   logic [27:0] s_raw, b_raw, s_obs, b_obs;
   assign s_raw = {s_finish, s_en, s_we, s_addr, s_zero_row, s_left_edge, s_right_edge,
                   s_wr_valid, s_ld_valid, s_ld_slot, s_shift, s_row_start};
   assign b_raw = {b_finish, b_en, b_we, b_addr, b_zero_row, b_left_edge, b_right_edge,
                   b_wr_valid, b_ld_valid, b_ld_slot, b_shift, b_row_start};
   // Address is don't-care while no access is requested
   assign s_obs = s_en ? s_raw : {s_raw[27:25], 16'h0, s_raw[8:0]};
   assign b_obs = b_en ? b_raw : {b_raw[27:25], 16'h0, b_raw[8:0]};

   function automatic logic [27:0] ev(input logic fin, input logic e, input logic w,
                                      input logic [15:0] a, input logic z, input logic l,
                                      input logic r, input logic ldv, input logic [1:0] sl,
                                      input logic sh, input logic rs);
      return {fin, e, w, a, z, l, r, e & w, ldv, sl, sh, rs};
   endfunction

   task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic [27:0] exp_s [0:14];

   task automatic fill_small_table();
      exp_s[0]  = ev(0, 1, 1, 16'd6,  1, 1, 0, 0, 2'd0, 0, 0);
      exp_s[1]  = ev(0, 1, 1, 16'd7,  1, 0, 1, 0, 2'd0, 0, 0);
      exp_s[2]  = ev(0, 1, 0, 16'd0,  0, 0, 0, 0, 2'd0, 0, 0);
      exp_s[3]  = ev(0, 1, 0, 16'd2,  0, 0, 0, 1, 2'd0, 0, 1);
      exp_s[4]  = ev(0, 1, 0, 16'd4,  0, 0, 0, 1, 2'd1, 0, 0);
      exp_s[5]  = ev(0, 0, 0, 16'd0,  0, 0, 0, 1, 2'd2, 0, 0);
      exp_s[6]  = ev(0, 1, 0, 16'd1,  0, 0, 0, 0, 2'd0, 0, 0);
      exp_s[7]  = ev(0, 1, 0, 16'd3,  0, 0, 0, 1, 2'd0, 1, 0);
      exp_s[8]  = ev(0, 1, 0, 16'd5,  0, 0, 0, 1, 2'd1, 0, 0);
      exp_s[9]  = ev(0, 0, 0, 16'd0,  0, 0, 0, 1, 2'd2, 0, 0);
      exp_s[10] = ev(0, 1, 1, 16'd8,  0, 1, 0, 0, 2'd0, 0, 0);
      exp_s[11] = ev(0, 1, 1, 16'd9,  0, 0, 1, 0, 2'd0, 0, 0);
      exp_s[12] = ev(0, 1, 1, 16'd10, 1, 1, 0, 0, 2'd0, 0, 0);
      exp_s[13] = ev(0, 1, 1, 16'd11, 1, 0, 1, 0, 2'd0, 0, 0);
      exp_s[14] = ev(1, 0, 0, 16'd0,  0, 0, 0, 0, 2'd0, 0, 0);
   endtask

   // Full 4x8 job: reads against an ordered model, writes against a coverage map
   task automatic run_big();
      int q[$];
      int idx, wr_cnt, rd_cnt, sh_cnt, rs_cnt, a, exp_a;
      logic [31:0] seen;
      for (int r = 1; r <= 6; r++)
         for (int c = 0; c < 4; c++) begin
            q.push_back((r - 1) * 4 + c);
            q.push_back(r * 4 + c);
            q.push_back((r + 1) * 4 + c);
         end
      seen = '0;
      idx = 0; wr_cnt = 0; rd_cnt = 0; sh_cnt = 0; rs_cnt = 0;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      while (!b_finish && idx < 400) begin
         if (b_en && b_we) begin
            wr_cnt++;
            a = int'(b_addr) - 32;
            check_int("big_wr_range", int'(a >= 0 && a < 32), 1);
            if (a >= 0 && a < 32) begin
               check_int("big_wr_once", int'(seen[a]), 0);
               seen[a] = 1'b1;
               check_int("big_wr_flags",
                         int'({b_zero_row, b_left_edge, b_right_edge}),
                         int'({(a / 4 == 0) || (a / 4 == 7), a % 4 == 0, a % 4 == 3}));
            end
         end else if (b_en) begin
            rd_cnt++;
            exp_a = (q.size() > 0) ? q.pop_front() : -1;
            check_int("big_rd_addr", int'(b_addr), exp_a);
         end
         if (b_ld_valid && b_shift) sh_cnt++;
         if (b_ld_valid && b_row_start) rs_cnt++;
         @(negedge clk);
         idx++;
      end
      check_int("big_finish_cycle", idx, 2 * 4 + 6 * 20);
      check_int("big_writes", wr_cnt, 32);
      check_int("big_reads", rd_cnt, 72);
      check_int("big_all_written", int'(seen == 32'hFFFF_FFFF), 1);
      check_int("big_shifts", sh_cnt, 18);
      check_int("big_row_starts", rs_cnt, 6);
   endtask

   initial begin
      int idx;
      fill_small_table();
      reset   = 1'b1;
      start_s = 1'b0;
      start_b = 1'b0;
      #1;
      check("reset_small", s_raw, 28'h0);
      check("reset_big", b_raw, 28'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("idle_small", s_raw, 28'h0);

      // Single-cycle start: full trace of the 2x3 job
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int i = 0; i <= 14; i++) begin
         check($sformatf("run1_c%0d", i), s_obs, exp_s[i]);
         if (i < 14) @(negedge clk);
      end

      // start held high through DONE: no restart, finish stays up
      start_s = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("done_hold_%0d", k), s_obs, exp_s[14]);
      end
      start_s = 1'b0;
      @(negedge clk);
      check("finish_drop", s_raw, 28'h0);

      // Rerun with start pulsed again mid interior row: trace must be unchanged
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int i = 0; i <= 14; i++) begin
         check($sformatf("run2_c%0d", i), s_obs, exp_s[i]);
         start_s = (i == 4 || i == 7);
         if (i < 14) @(negedge clk);
      end
      start_s = 1'b0;

      // 4x8 job
      @(negedge clk);
      run_big();
      @(negedge clk);

      // Reset during RD1 of row 5, then restart with start held
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      repeat (85) @(negedge clk);
      check("big_rd1_row5", b_obs, ev(0, 1, 0, 16'd20, 0, 0, 0, 1, 2'd0, 0, 1));
      #2 reset = 1'b1;
      #1;
      check("async_reset_big", b_raw, 28'h0);
      @(negedge clk);
      check("held_reset_big", b_raw, 28'h0);
      reset   = 1'b0;
      start_b = 1'b1;
      @(negedge clk);
      check("restart_first", b_obs, ev(0, 1, 1, 16'd32, 1, 1, 0, 0, 2'd0, 0, 0));
      start_b = 1'b0;
      idx = 0;
      while (!b_finish && idx < 400) begin
         @(negedge clk);
         idx++;
      end
      check_int("restart_finish_cycle", idx, 128);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
